// File: rtl/pal_cfg_loader.sv
// Serial loader for the PAL configuration chain: W-bit words in, one bit per cycle out, MSB first.
// Optional checksum word after the data is enabled by defining PAL_CFG_CHECKSUM_EN.
module pal_cfg_loader #(
    parameter int N = 8,
    parameter int M = 8,
    parameter int P = 8,
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         start_i,
    input  logic         abort_i,
    input  logic [W-1:0] word_in_i,
    input  logic         word_valid_i,
    output logic         word_ready_o,
    output logic         cfg_data_o,
    output logic         cfg_shift_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         err_o
);
    localparam int SR_LEN = 2*N*P + P*M;
    localparam int CNT_W  = $clog2(SR_LEN+1);
    localparam int WC_W   = $clog2(W+1);

    // state     | meaning
    // S_IDLE    | no load active, waiting for start
    // S_WAIT_WORD | ready high, waiting for the next bitstream word
    // S_SHIFT   | one bit on cfg_data, cfg_shift high
    // S_CHECK   | ready high for the checksum word (checksum build only)
    // S_DONE    | all bits shifted, done held until start or abort
    typedef enum logic [2:0] {S_IDLE, S_WAIT_WORD, S_SHIFT, S_CHECK, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WC_W-1:0]   wcnt_q, wcnt_d;
    logic [W-1:0]      sr_q, sr_d;
    logic              word_ready_q, word_ready_d;
    logic              cfg_data_q, cfg_data_d;
    logic              cfg_shift_q, cfg_shift_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
`ifdef PAL_CFG_CHECKSUM_EN
    logic [W-1:0]      csum_q, csum_d;
    logic              err_q, err_d;
`endif

    logic hs, start_go, abort_go;
    assign hs       = word_valid_i && word_ready_q;
    assign start_go = start_i && !abort_i && (state_q == S_IDLE || state_q == S_DONE);
    assign abort_go = abort_i && (state_q != S_IDLE);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (start_go) state_d = S_WAIT_WORD;
            S_WAIT_WORD: if (hs) state_d = S_SHIFT;
            S_SHIFT: begin
                if (cnt_q == CNT_W'(SR_LEN)) begin
`ifdef PAL_CFG_CHECKSUM_EN
                    state_d = S_CHECK;
`else
                    state_d = S_DONE;
`endif
                end else if (wcnt_q == WC_W'(W)) begin
                    state_d = S_WAIT_WORD;
                end
            end
`ifdef PAL_CFG_CHECKSUM_EN
            S_CHECK:     if (hs) state_d = S_IDLE;
`endif
            S_DONE:      if (start_go) state_d = S_WAIT_WORD;
            default:     state_d = S_IDLE;
        endcase
        if (abort_go) state_d = S_IDLE;
    end

    // Outputs are computed from the next state so every port comes straight from a flop.
    always_comb begin
        cnt_d        = cnt_q;
        wcnt_d       = wcnt_q;
        sr_d         = sr_q;
        done_d       = done_q;
        cfg_data_d   = 1'b0;
        word_ready_d = (state_d == S_WAIT_WORD) || (state_d == S_CHECK);
        cfg_shift_d  = (state_d == S_SHIFT);
        busy_d       = (state_d == S_WAIT_WORD) || (state_d == S_SHIFT) || (state_d == S_CHECK);
`ifdef PAL_CFG_CHECKSUM_EN
        csum_d       = csum_q;
        err_d        = err_q;
`endif
        if (start_go) begin
            cnt_d  = '0;
            done_d = 1'b0;
`ifdef PAL_CFG_CHECKSUM_EN
            csum_d = '0;
            err_d  = 1'b0;
`endif
        end
        if (state_d == S_SHIFT) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (state_q == S_WAIT_WORD) begin
                cfg_data_d = word_in_i[W-1];
                sr_d       = word_in_i << 1;
                wcnt_d     = WC_W'(1);
`ifdef PAL_CFG_CHECKSUM_EN
                csum_d     = csum_q ^ word_in_i;
`endif
            end else begin
                cfg_data_d = sr_q[W-1];
                sr_d       = sr_q << 1;
                wcnt_d     = wcnt_q + WC_W'(1);
            end
        end
        if (state_q == S_SHIFT && state_d == S_DONE) done_d = 1'b1;
`ifdef PAL_CFG_CHECKSUM_EN
        if (state_q == S_CHECK && hs && !abort_go) begin
            if (word_in_i == csum_q) done_d = 1'b1;
            else                     err_d  = 1'b1;
        end
`endif
        if (abort_go) done_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q        <= '0;
            wcnt_q       <= '0;
            sr_q         <= '0;
            word_ready_q <= 1'b0;
            cfg_data_q   <= 1'b0;
            cfg_shift_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef PAL_CFG_CHECKSUM_EN
            csum_q       <= '0;
            err_q        <= 1'b0;
`endif
        end else begin
            cnt_q        <= cnt_d;
            wcnt_q       <= wcnt_d;
            sr_q         <= sr_d;
            word_ready_q <= word_ready_d;
            cfg_data_q   <= cfg_data_d;
            cfg_shift_q  <= cfg_shift_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef PAL_CFG_CHECKSUM_EN
            csum_q       <= csum_d;
            err_q        <= err_d;
`endif
        end
    end

    assign word_ready_o = word_ready_q;
    assign cfg_data_o   = cfg_data_q;
    assign cfg_shift_o  = cfg_shift_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
`ifdef PAL_CFG_CHECKSUM_EN
    assign err_o        = err_q;
`else
    assign err_o        = 1'b0;
`endif

endmodule

// File: tb/tb_pal_cfg_loader.sv
// Bench for pal_cfg_loader with N=M=P=2, W=8 (12-bit chain); expected bits are queued
// when words are offered and checked against cfg_data on every cfg_shift cycle.
module tb_pal_cfg_loader;
    localparam int N = 2, M = 2, P = 2, W = 8;
    localparam int SR_LEN = 12;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] word_in = '0;
    logic         word_valid = 1'b0;
    logic         word_ready, cfg_data, cfg_shift, busy, done, err;

    int checks = 0;
    int errors = 0;

    logic              exp_q[$];
    logic              exp_bit;
    logic [SR_LEN-1:0] pal_chain = '0;
    int                shift_cnt = 0;

    pal_cfg_loader #(.N(N), .M(M), .P(P), .W(W)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .abort_i(abort),
        .word_in_i(word_in), .word_valid_i(word_valid), .word_ready_o(word_ready),
        .cfg_data_o(cfg_data), .cfg_shift_o(cfg_shift), .busy_o(busy),
        .done_o(done), .err_o(err)
    );

    always #5 clk = ~clk;

    // PAL chain model plus scoreboard pop: first shifted bit ends at the MSB.
    always @(negedge clk) begin
        if (cfg_shift === 1'b1) begin
            pal_chain = {pal_chain[SR_LEN-2:0], cfg_data};
            shift_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_shift: cfg_shift high with no bit expected, shift_cnt=%0d", shift_cnt);
            end else begin
                exp_bit = exp_q.pop_front();
                if (cfg_data !== exp_bit) begin
                    errors++;
                    $display("FAIL cfg_data bit %0d: got %b expected %b", shift_cnt, cfg_data, exp_bit);
                end
            end
            checks++;
            if (word_ready !== 1'b0) begin
                errors++;
                $display("FAIL ready_in_shift: word_ready=%b expected 0", word_ready);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_model();
        exp_q.delete();
        pal_chain = '0;
        shift_cnt = 0;
    endtask

    task automatic start_pulse();
        tick(); start = 1'b1;
        tick(); start = 1'b0;
    endtask

    task automatic send_word(input logic [W-1:0] w, input int nbits, input int gap);
        int t;
        if (gap > 0) begin
            t = 0;
            while (word_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
            checks++;
            if (word_ready !== 1'b1) begin
                errors++;
                $display("FAIL ready_timeout: word_ready=%b expected 1", word_ready);
            end
            repeat (gap) begin
                @(negedge clk);
                checks++;
                if (word_ready !== 1'b1 || cfg_shift !== 1'b0) begin
                    errors++;
                    $display("FAIL gap_hold: ready=%b shift=%b expected 1 0", word_ready, cfg_shift);
                end
            end
            tick();
        end
        for (int i = 0; i < nbits; i++) exp_q.push_back(w[W-1-i]);
        word_in    = w;
        word_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (word_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        checks++;
        if (word_ready !== 1'b1) begin
            errors++;
            $display("FAIL hs_timeout: word_ready=%b expected 1", word_ready);
        end
        tick();
        word_valid = 1'b0;
    endtask

    task automatic wait_not_busy(output bit ok);
        int t = 0;
        @(negedge clk);
        while (busy !== 1'b0 && t < 200) begin @(negedge clk); t++; end
        ok = (busy === 1'b0);
        #1;
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if ({word_ready, cfg_data, cfg_shift, busy, done, err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {word_ready, cfg_data, cfg_shift, busy, done, err});
        end
        repeat (2) tick();
        rst_n = 1'b1;
        clear_model();
        start_pulse();
        send_word(8'hA5, 8, 0);
        while (shift_cnt < 3) begin @(negedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({word_ready, cfg_data, cfg_shift, busy, done, err} !== 6'b0) begin
            errors++;
            $display("FAIL midrun_reset: got %b expected 000000",
                     {word_ready, cfg_data, cfg_shift, busy, done, err});
        end
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (word_ready !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL post_reset_idle: ready=%b busy=%b expected 0 0", word_ready, busy);
            end
        end
    endtask

    task automatic test_basic_load(input int gap);
        bit ok;
        clear_model();
        start_pulse();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL start_busy gap%0d: busy=%b done=%b expected 1 0", gap, busy, done);
        end
        send_word(8'hA5, 8, 0);
        send_word(8'h3C, 4, gap);
        wait_not_busy(ok);
        checks++;
        if (!ok || done !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL load_done gap%0d: busy=%b done=%b err=%b expected 0 1 0", gap, busy, done, err);
        end
        checks++;
        if (pal_chain !== 12'hA53 || shift_cnt != SR_LEN || exp_q.size() != 0) begin
            errors++;
            $display("FAIL load_chain gap%0d: chain=%h shifts=%0d left=%0d expected a53 12 0",
                     gap, pal_chain, shift_cnt, exp_q.size());
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (shift_cnt != SR_LEN || done !== 1'b1) begin
            errors++;
            $display("FAIL done_hold gap%0d: shifts=%0d done=%b expected 12 1", gap, shift_cnt, done);
        end
    endtask

    task automatic test_abort();
        bit ok;
        clear_model();
        start_pulse();
        send_word(8'hA5, 8, 0);
        while (shift_cnt < 6) begin @(negedge clk); #1; end
        abort = 1'b1;
        start = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b0;
        exp_q.delete();
        checks++;
        if ({busy, done, cfg_shift, word_ready} !== 4'b0) begin
            errors++;
            $display("FAIL abort_idle: busy/done/shift/ready=%b expected 0000",
                     {busy, done, cfg_shift, word_ready});
        end
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (shift_cnt != 6 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_stop: shifts=%0d busy=%b expected 6 0", shift_cnt, busy);
        end
        clear_model();
        start_pulse();
        send_word(8'hA5, 8, 0);
        send_word(8'h3C, 4, 0);
        wait_not_busy(ok);
        checks++;
        if (!ok || done !== 1'b1 || pal_chain !== 12'hA53 || shift_cnt != SR_LEN) begin
            errors++;
            $display("FAIL reload_after_abort: done=%b chain=%h shifts=%0d expected 1 a53 12",
                     done, pal_chain, shift_cnt);
        end
    endtask

    task automatic test_start_while_busy();
        bit ok;
        clear_model();
        start_pulse();
        send_word(8'hA5, 8, 0);
        while (shift_cnt < 3) begin @(negedge clk); #1; end
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_start_ignored: busy=%b expected 1", busy);
        end
        send_word(8'h3C, 4, 0);
        wait_not_busy(ok);
        checks++;
        if (!ok || done !== 1'b1 || pal_chain !== 12'hA53 || shift_cnt != SR_LEN) begin
            errors++;
            $display("FAIL busy_start_load: done=%b chain=%h shifts=%0d expected 1 a53 12",
                     done, pal_chain, shift_cnt);
        end
    endtask

`ifdef PAL_CFG_CHECKSUM_EN
    task automatic test_checksum(input logic [W-1:0] csum, input logic exp_done);
        bit ok;
        clear_model();
        start_pulse();
        send_word(8'hA5, 8, 0);
        send_word(8'h3C, 4, 0);
        send_word(csum, 0, 0);
        wait_not_busy(ok);
        checks++;
        if (!ok || done !== exp_done || err !== !exp_done || pal_chain !== 12'hA53) begin
            errors++;
            $display("FAIL checksum %h: done=%b err=%b chain=%h expected %b %b a53",
                     csum, done, err, pal_chain, exp_done, !exp_done);
        end
    endtask
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic_load(0);
        test_basic_load(5);
        test_abort();
        test_start_while_busy();
`ifdef PAL_CFG_CHECKSUM_EN
        test_checksum(8'h99, 1'b1);
        test_checksum(8'h98, 1'b0);
`endif
        repeat (2) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
